// File: rtl/player_life_controller_pkg.sv
// Shared types for the player life controller: life-cycle state encoding and lives width.
package player_pkg;

    localparam int LIVES_W = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAY      = 3'd1,
        HIT       = 3'd2,
        RESPAWN   = 3'd3,
        GAME_OVER = 3'd4
    } player_state_t;

endpackage

// File: rtl/player_life_controller_frame_counter.sv
// Frame-pulse counter with synchronous clear; done flags the pulse that reaches the terminal value.
module frame_counter #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             startOfFrame,
    input  logic [CNT_W-1:0] terminal,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    // done is independent of clear so the owner can use it to drive clear
    assign done = startOfFrame && (count == terminal - 1'b1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (startOfFrame) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/player_life_controller.sv
// Player life-cycle sequencer: lives, hit/respawn timing, movement gating and sprite visibility.
module player_life_controller
    import player_pkg::*;
#(
    parameter int INITIAL_LIVES = 3,
    parameter int HIT_FRAMES    = 30,
    parameter int INVULN_FRAMES = 60,
    parameter int BLINK_FRAMES  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               startGame,
    input  logic               left,
    input  logic               right,
    input  logic               collision,
    input  logic               god_mode,
    output logic               moveLeft,
    output logic               moveRight,
    output logic               respawn,
    output logic               playerVisible,
    output logic [LIVES_W-1:0] lives,
    output logic               gameOver,
    output logic [2:0]         state
);

    localparam int MAX_FRAMES = (HIT_FRAMES > INVULN_FRAMES) ? HIT_FRAMES : INVULN_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    player_state_t      cur_state, next_state;
    logic [LIVES_W-1:0] lives_next;
    logic               respawn_next;
    logic               start_d, start_rise;
    logic [CNT_W-1:0]   count, terminal, blink_idx;
    logic               clear, done;

    assign start_rise = startGame & ~start_d;
    assign state      = cur_state;
    assign terminal   = (cur_state == HIT) ? CNT_W'(HIT_FRAMES) : CNT_W'(INVULN_FRAMES);
    assign blink_idx  = count / CNT_W'(BLINK_FRAMES);
    // Held at zero outside timed states, and zeroed on the terminal pulse for the next phase
    assign clear      = ((cur_state != HIT) && (cur_state != RESPAWN)) || done;

    frame_counter #(.CNT_W(CNT_W)) u_frame_counter (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .startOfFrame (startOfFrame),
        .terminal     (terminal),
        .count        (count),
        .done         (done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= IDLE;
            lives     <= LIVES_W'(INITIAL_LIVES);
            respawn   <= 1'b0;
            start_d   <= 1'b0;
        end else begin
            cur_state <= next_state;
            lives     <= lives_next;
            respawn   <= respawn_next;
            start_d   <= startGame;
        end
    end

    always_comb begin
        next_state    = cur_state;
        lives_next    = lives;
        respawn_next  = 1'b0;
        moveLeft      = 1'b0;
        moveRight     = 1'b0;
        playerVisible = 1'b0;
        gameOver      = 1'b0;
        case (cur_state)
            IDLE, GAME_OVER: begin
                gameOver = (cur_state == GAME_OVER);
                if (start_rise) begin
                    next_state   = PLAY;
                    lives_next   = LIVES_W'(INITIAL_LIVES);
                    respawn_next = 1'b1;
                end
            end
            PLAY: begin
                playerVisible = 1'b1;
                moveLeft      = left & ~right;
                moveRight     = right & ~left;
                if (collision && !god_mode) begin
                    next_state = HIT;
                    lives_next = (lives == '0) ? '0 : lives - 1'b1;
                end
            end
            HIT: begin
                if (done) begin
                    if (lives == '0) begin
                        next_state = GAME_OVER;
                    end else begin
                        next_state   = RESPAWN;
                        respawn_next = 1'b1;
                    end
                end
            end
            RESPAWN: begin
                playerVisible = ~blink_idx[0];
                moveLeft      = left & ~right;
                moveRight     = right & ~left;
                if (done) begin
                    next_state = PLAY;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_player_life_controller.sv
// Bench for player_life_controller: vector table, corner sequences and random run vs a frame-level model.
module tb_player_life_controller;

    localparam int INIT = 3;
    localparam int HITF = 30;
    localparam int INV  = 60;
    localparam int BLK  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sof = 1'b0, start = 1'b0, left = 1'b0, right = 1'b0;
    logic       collision = 1'b0, god = 1'b0;
    logic       moveLeft, moveRight, respawn, playerVisible, gameOver;
    logic [2:0] lives, state;

    always #5 clk = ~clk;

    player_life_controller #(
        .INITIAL_LIVES (INIT),
        .HIT_FRAMES    (HITF),
        .INVULN_FRAMES (INV),
        .BLINK_FRAMES  (BLK)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (sof),
        .startGame     (start),
        .left          (left),
        .right         (right),
        .collision     (collision),
        .god_mode      (god),
        .moveLeft      (moveLeft),
        .moveRight     (moveRight),
        .respawn       (respawn),
        .playerVisible (playerVisible),
        .lives         (lives),
        .gameOver      (gameOver),
        .state         (state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Frame-level model: phase number, lives left, frames remaining in the timed phase
    int m_phase, m_lives, m_rem;
    bit m_resp, m_prev_start;

    typedef struct {
        bit         st, l, r, c, g;
        logic [2:0] e_state, e_lives;
        bit         e_ml, e_mr, e_vis, e_resp;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_phase = 0; m_lives = INIT; m_rem = 0; m_resp = 0; m_prev_start = 0;
    endtask

    task automatic model_check();
        bit active, eml, emr, evis;
        active = (m_phase == 1) || (m_phase == 3);
        eml    = active && left && !right;
        emr    = active && right && !left;
        evis   = (m_phase == 1) || (m_phase == 3 && (((INV - m_rem) / BLK) % 2 == 0));
        chk("m_state",   8'(state),         8'(m_phase));
        chk("m_lives",   8'(lives),         8'(m_lives));
        chk("m_left",    8'(moveLeft),      8'(eml));
        chk("m_right",   8'(moveRight),     8'(emr));
        chk("m_visible", 8'(playerVisible), 8'(evis));
        chk("m_respawn", 8'(respawn),       8'(m_resp));
        chk("m_gameover",8'(gameOver),      8'(m_phase == 4));
    endtask

    task automatic model_clock();
        bit rise;
        rise = start && !m_prev_start;
        m_prev_start = start;
        m_resp = 0;
        case (m_phase)
            0, 4: if (rise) begin m_phase = 1; m_lives = INIT; m_resp = 1; end
            1: if (collision && !god) begin
                m_phase = 2; m_rem = HITF;
                if (m_lives > 0) m_lives = m_lives - 1;
            end
            2: if (sof) begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_lives == 0) m_phase = 4;
                    else begin m_phase = 3; m_rem = INV; m_resp = 1; end
                end
            end
            3: if (sof) begin
                m_rem--;
                if (m_rem == 0) m_phase = 1;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic drive(input bit s, input bit st, input bit l, input bit r, input bit c, input bit g);
        @(negedge clk);
        sof = s; start = st; left = l; right = r; collision = c; god = g;
        #1;
    endtask

    task automatic finish_cycle();
        model_check();
        model_clock();
        @(posedge clk);
    endtask

    task automatic step(input bit s, input bit st, input bit l, input bit r, input bit c, input bit g);
        drive(s, st, l, r, c, g);
        finish_cycle();
    endtask

    task automatic frame(input bit c);
        step(1, 0, 0, 0, c, 0);
        step(0, 0, 0, 0, c, 0);
        step(0, 0, 1, 0, c, 0);
    endtask

    initial begin
        //         st l r c g  state lives ml mr vis resp
        tbl[0]  = '{0,0,0,0,0, 3'd0, 3'd3, 0, 0, 0, 0};
        tbl[1]  = '{1,0,0,0,0, 3'd0, 3'd3, 0, 0, 0, 0};
        tbl[2]  = '{1,0,1,0,0, 3'd1, 3'd3, 0, 1, 1, 1};
        tbl[3]  = '{1,1,1,0,0, 3'd1, 3'd3, 0, 0, 1, 0};
        tbl[4]  = '{0,1,0,0,0, 3'd1, 3'd3, 1, 0, 1, 0};
        tbl[5]  = '{0,1,0,1,1, 3'd1, 3'd3, 1, 0, 1, 0};
        tbl[6]  = '{0,0,0,1,1, 3'd1, 3'd3, 0, 0, 1, 0};
        tbl[7]  = '{0,0,0,1,0, 3'd1, 3'd3, 0, 0, 1, 0};
        tbl[8]  = '{0,0,1,1,0, 3'd2, 3'd2, 0, 0, 0, 0};
        tbl[9]  = '{0,0,1,1,0, 3'd2, 3'd2, 0, 0, 0, 0};
        tbl[10] = '{1,0,0,1,0, 3'd2, 3'd2, 0, 0, 0, 0};
        tbl[11] = '{0,0,0,1,1, 3'd2, 3'd2, 0, 0, 0, 0};

        // Reset values
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_lives", 8'(lives), 8'd3);
        chk("rst_outs",  8'({moveLeft, moveRight, respawn, playerVisible, gameOver}), 8'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(0, tbl[i].st, tbl[i].l, tbl[i].r, tbl[i].c, tbl[i].g);
            chk("tv_state",   8'(state),         8'(tbl[i].e_state));
            chk("tv_lives",   8'(lives),         8'(tbl[i].e_lives));
            chk("tv_left",    8'(moveLeft),      8'(tbl[i].e_ml));
            chk("tv_right",   8'(moveRight),     8'(tbl[i].e_mr));
            chk("tv_visible", 8'(playerVisible), 8'(tbl[i].e_vis));
            chk("tv_respawn", 8'(respawn),       8'(tbl[i].e_resp));
            finish_cycle();
        end

        // HIT lasts exactly HITF frame pulses, then RESPAWN with pulse
        repeat (HITF - 1) frame(0);
        drive(1, 0, 0, 0, 0, 0);
        chk("hit_last", 8'(state), 8'd2);
        finish_cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("respawn_enter", 8'(state), 8'd3);
        chk("respawn_pulse", 8'(respawn), 8'd1);
        finish_cycle();
        // Collision during RESPAWN is ignored
        repeat (INV - 1) frame(1);
        chk("respawn_nodec", 8'(lives), 8'd2);
        step(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("back_to_play", 8'(state), 8'd1);
        finish_cycle();

        // Collision coincident with a frame pulse: counting starts from zero
        step(1, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("coinc_hit", 8'(state), 8'd2);
        chk("coinc_lives", 8'(lives), 8'd1);
        finish_cycle();
        repeat (HITF - 1) frame(0);
        drive(0, 0, 0, 0, 0, 0);
        chk("coinc_still_hit", 8'(state), 8'd2);
        finish_cycle();
        step(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("coinc_respawn", 8'(state), 8'd3);
        finish_cycle();
        repeat (INV) frame(0);

        // Asynchronous reset mid-HIT
        step(0, 0, 0, 0, 1, 0);
        repeat (3) frame(0);
        @(negedge clk);
        left = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("arst_state", 8'(state), 8'd0);
        chk("arst_lives", 8'(lives), 8'd3);
        chk("arst_outs",  8'({moveLeft, moveRight, respawn, playerVisible, gameOver}), 8'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Three hits exhaust lives and end in GAME_OVER, then restart
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < INIT; k++) begin
            step(0, 0, 0, 0, 1, 0);
            repeat (HITF) frame(0);
            if (k < INIT - 1) repeat (INV) frame(0);
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("go_state", 8'(state), 8'd4);
        chk("go_flag",  8'(gameOver), 8'd1);
        chk("go_lives", 8'(lives), 8'd0);
        finish_cycle();
        step(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("restart_state", 8'(state), 8'd1);
        chk("restart_lives", 8'(lives), 8'd3);
        chk("restart_pulse", 8'(respawn), 8'd1);
        finish_cycle();

        // Randomized run against the model
        for (int n = 0; n < 4000; n++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/player_life_controller.md
# player_life_controller

Sequencing controller for the player datapath. Owns the player life cycle (idle, play, hit, respawn/invulnerable, game over), gates the left/right commands into the player movement block, issues the respawn pulse that returns the player to its initial coordinate, and drives the player's visibility/blink to the drawing layer. Sits between the keyboard decoder / collision detector and the player movement and drawing blocks; all timing is counted in frames via `startOfFrame`.

## Interface
- `INITIAL_LIVES`, 3, lives loaded on game start (1..7)
- `HIT_FRAMES`, 30, frames spent in HIT (explosion) before respawn/game over
- `INVULN_FRAMES`, 60, frames of post-respawn invulnerability
- `BLINK_FRAMES`, 4, half-period of the invulnerability blink, in frames
- `clk` in 1 system clock
- `reset` in 1 asynchronous, active-high reset
- `startOfFrame` in 1 one-cycle pulse per frame
- `startGame` in 1 level from keyboard; rising edge detected internally
- `left`, `right` in 1 raw movement requests
- `collision` in 1 player-vs-hazard hit, single or multi-cycle
- `god_mode` in 1 collisions ignored while high
- `moveLeft`, `moveRight` out 1 gated movement commands to the player movement block
- `respawn` out 1 one-cycle pulse: reload player to initial coordinate
- `playerVisible` out 1 draw enable for the player sprite
- `lives` out 3 remaining lives
- `gameOver` out 1 high in GAME_OVER
- `state` out 3 current state encoding, for debug/HUD

## Operation
- States: IDLE, PLAY, HIT, RESPAWN, GAME_OVER.
- Reset: state IDLE, `lives`=INITIAL_LIVES, frame counter 0, start-edge register 0; all 1-bit outputs 0.
- Start edge: `startRise` = `startGame` & ~`startGame_d`; `startGame_d` registered every cycle.
- IDLE: `startRise` -> PLAY, `lives`<=INITIAL_LIVES, `respawn` pulses.
- PLAY: `playerVisible`=1; `moveLeft`=left&~right, `moveRight`=right&~left. `collision`&~`god_mode` -> HIT, `lives`<=lives-1, counter cleared.
- HIT: movement 0, visible 0. Counter increments on each `startOfFrame`; when it reaches HIT_FRAMES: lives==0 -> GAME_OVER, else -> RESPAWN with `respawn` pulse, counter cleared.
- RESPAWN: movement gated as in PLAY; `collision` ignored; `playerVisible` = 1 when (counter / BLINK_FRAMES) even, else 0. Counter reaching INVULN_FRAMES -> PLAY.
- GAME_OVER: `gameOver`=1, movement 0, visible 0; `startRise` -> PLAY, lives reloaded, `respawn` pulses.
- Boundary rules:
  - collision and `startOfFrame` in the same PLAY cycle: collision wins, counter starts from 0.
  - collision held across many cycles: exactly one decrement (only PLAY decrements).
  - collision in IDLE/HIT/RESPAWN/GAME_OVER: ignored.
  - `god_mode` changes only affect PLAY-state hit detection; an in-progress HIT completes.
  - `startRise` outside IDLE/GAME_OVER: ignored.
  - `lives` never wraps below 0; decrement from 1 reaches 0 and ends in GAME_OVER.
  - `reset` mid-operation: immediate return to reset values regardless of state.

## Timing
- State, `lives`, counter, `respawn`, `startGame_d` registered on `posedge clk`; `reset` asynchronous.
- `moveLeft`, `moveRight`, `playerVisible`, `gameOver` are combinational decodes of registered state/counter and current `left`/`right`, with zero-cycle input-to-output latency for movement.
- Collision to HIT and `lives` update: 1 clock.
- `respawn` is high exactly one clock, coincident with the first cycle of the new state (PLAY or RESPAWN).
- HIT duration: HIT_FRAMES `startOfFrame` pulses. RESPAWN duration: INVULN_FRAMES `startOfFrame` pulses. The transition occurs on the clock of the terminal pulse.

## Structure
- Package `player_pkg`: `player_state_t` enum (IDLE=0, PLAY=1, HIT=2, RESPAWN=3, GAME_OVER=4), `LIVES_W`=3.
- Sub-module `frame_counter`:
  - Inputs: clk, reset, clear, `startOfFrame`, terminal value.
  - Outputs: count, `done` (asserted on the terminal pulse).
  - Used for both HIT and RESPAWN timing.
- The top level holds the FSM, lives register, start-edge detect and output decode.

## Test plan
- Reset then `startGame` 0->1: `respawn` one-cycle pulse; state PLAY; `lives`=3; `playerVisible`=1; `right`=1,`left`=0 -> `moveRight`=1 same cycle; both high -> both outputs 0.
- In PLAY, `collision` held 5 cycles, `god_mode`=0: `lives` 3->2 once; HIT; after 30 frame pulses, RESPAWN with `respawn` pulse; `playerVisible` toggles every 4 frames; after 60 frames, back in PLAY.
- `god_mode`=1 with `collision` pulses in PLAY: state remains PLAY; `lives` unchanged at 3.
- Three hits with INITIAL_LIVES=3: `lives` reaches 0; after the HIT frames, GAME_OVER with `gameOver`=1; new `startGame` edge -> PLAY, `lives`=3.
- `collision` coincident with `startOfFrame`: HIT lasts exactly 30 subsequent pulses. Collision during RESPAWN: no decrement.
- Assert `reset` mid-HIT: all outputs 0, state IDLE, `lives`=3 asynchronously, before the next clock edge.
